// File: rtl/sync_fifo_wr_arb_if.sv
// ----------------------------------------------------------------------------
// sync_fifo_wr_arb_if
//
// Bundles the producer-side valid/ready/last/data handshake and the sync_fifo
// write-side signals used by sync_fifo_wr_arb.
//
// Parameters
//   NUM_REQ     number of producers
//   DATA_WIDTH  beat width
//
// Signals
//   req_valid   producer -> arbiter   per-producer beat valid
//   req_last    producer -> arbiter   per-producer end-of-packet (qualified by valid)
//   req_data    producer -> arbiter   producer i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready   arbiter  -> producer  per-producer beat accepted when valid & ready
//   fifo_full   fifo     -> arbiter   sync_fifo full
//   fifo_wr_en  arbiter  -> fifo      sync_fifo wr_en
//   fifo_din    arbiter  -> fifo      sync_fifo din
//
// Modports
//   master  arbiter side (drives ready and the fifo write port)
//   slave   environment side (producers and fifo)
// ----------------------------------------------------------------------------
interface sync_fifo_wr_arb_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_din;

    modport master (
        input  req_valid,
        input  req_last,
        input  req_data,
        input  fifo_full,
        output req_ready,
        output fifo_wr_en,
        output fifo_din
    );

    modport slave (
        output req_valid,
        output req_last,
        output req_data,
        output fifo_full,
        input  req_ready,
        input  fifo_wr_en,
        input  fifo_din
    );
endinterface

// File: rtl/sync_fifo_wr_arb.sv
// ----------------------------------------------------------------------------
// sync_fifo_wr_arb
//
// Round-robin write arbiter sharing one sync_fifo write port between NUM_REQ
// producers. A producer is granted the port for one burst, which ends on an
// accepted beat carrying req_last or on the BURST_LEN-th accepted beat. Each
// grant costs one arbitration cycle in which no beat moves. While the fifo is
// full nothing is accepted and the grant is held.
//
// Parameters
//   NUM_REQ     number of producers (2..8)
//   DATA_WIDTH  beat width, equals sync_fifo INPUT_WIDTH
//   BURST_LEN   max beats per grant before forced re-arbitration (>= 1)
//   TIMEOUT     idle-cycle limit on a held grant (only with ARB_TIMEOUT_EN)
//
// Ports
//   sys_clk   in   clock, rising edge
//   sys_rst   in   asynchronous active-low reset
//   bus       if   sync_fifo_wr_arb_if.master: producer handshakes + fifo write
//   grant     out  one-hot current owner, 0 when arbitrating
//   grant_id  out  binary index of last/current owner
//   busy      out  1 while a grant is held
//
// Configuration
//   ARB_TIMEOUT_EN  when defined, a grant whose owner keeps req_valid low for
//                   TIMEOUT consecutive non-stalled cycles is released.
// ----------------------------------------------------------------------------
module sync_fifo_wr_arb #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned BURST_LEN  = 8,
    parameter int unsigned TIMEOUT    = 16,
    localparam int unsigned IdWidth   = $clog2(NUM_REQ)
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    sync_fifo_wr_arb_if.master    bus,
    output logic [NUM_REQ-1:0]    grant,
    output logic [IdWidth-1:0]    grant_id,
    output logic                  busy
);

    localparam int unsigned CntWidth = $clog2(BURST_LEN + 1);
    localparam logic [CntWidth-1:0] LastBeat = CntWidth'(BURST_LEN - 1);

    if (NUM_REQ < 2 || NUM_REQ > 8 || BURST_LEN < 1 || TIMEOUT < 1) begin : g_param_check
        $error("sync_fifo_wr_arb: parameter out of range");
    end

    typedef enum logic [0:0] {StArb, StGrant} state_e;

    state_e                state_q;
    logic [NUM_REQ-1:0]    grant_q;
    logic [IdWidth-1:0]    grant_id_q;
    logic [IdWidth-1:0]    rr_ptr_q;
    logic                  busy_q;
    logic [CntWidth-1:0]   beat_cnt_q;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned IdleWidth = $clog2(TIMEOUT + 1);
    localparam logic [IdleWidth-1:0] IdleLast = IdleWidth'(TIMEOUT - 1);

    logic [IdleWidth-1:0]  idle_cnt_q;
`endif

    logic                  owner_valid;
    logic                  owner_last;
    logic                  accept;
    logic                  burst_done;
    logic                  any_valid;
    logic                  found;
    logic [IdWidth-1:0]    cand;
    logic [IdWidth-1:0]    winner;
    logic [DATA_WIDTH-1:0] din;

    // Owner qualifiers. grant_q is all-zero while arbitrating, so every term
    // below is naturally inactive outside a grant and during reset.
    always_comb begin
        owner_valid = |(grant_q & bus.req_valid);
        owner_last  = |(grant_q & bus.req_last);
        accept      = owner_valid & ~bus.fifo_full;
        burst_done  = owner_last | (beat_cnt_q == LastBeat);
    end

    // Round-robin pick: first valid index after the previous winner.
    always_comb begin
        any_valid = |bus.req_valid;
        found     = 1'b0;
        cand      = '0;
        winner    = rr_ptr_q;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IdWidth'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && bus.req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Zero-latency data mux off the registered grant; zero when idle.
    always_comb begin
        din = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                din = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign bus.req_ready  = grant_q & {NUM_REQ{~bus.fifo_full}};
    assign bus.fifo_wr_en = accept;
    assign bus.fifo_din   = din;

    assign grant    = grant_q;
    assign grant_id = grant_id_q;
    assign busy     = busy_q;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q    <= StArb;
            grant_q    <= '0;
            grant_id_q <= '0;
            rr_ptr_q   <= IdWidth'(NUM_REQ - 1);
            busy_q     <= 1'b0;
            beat_cnt_q <= '0;
`ifdef ARB_TIMEOUT_EN
            idle_cnt_q <= '0;
`endif
        end else begin
            case (state_q)
                StArb: begin
                    if (any_valid) begin
                        state_q    <= StGrant;
                        grant_q    <= NUM_REQ'(1) << winner;
                        grant_id_q <= winner;
                        rr_ptr_q   <= winner;
                        busy_q     <= 1'b1;
                        beat_cnt_q <= '0;
`ifdef ARB_TIMEOUT_EN
                        idle_cnt_q <= '0;
`endif
                    end
                end
                StGrant: begin
                    if (accept) begin
`ifdef ARB_TIMEOUT_EN
                        idle_cnt_q <= '0;
`endif
                        // last and the BURST_LEN-th beat together still give
                        // exactly one release.
                        if (burst_done) begin
                            state_q    <= StArb;
                            grant_q    <= '0;
                            busy_q     <= 1'b0;
                            beat_cnt_q <= '0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + CntWidth'(1);
                        end
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (bus.fifo_full) begin
                        // A full stall is not the owner's fault.
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q == IdleLast) begin
                        state_q    <= StArb;
                        grant_q    <= '0;
                        busy_q     <= 1'b0;
                        beat_cnt_q <= '0;
                        idle_cnt_q <= '0;
                    end else begin
                        idle_cnt_q <= idle_cnt_q + IdleWidth'(1);
                    end
`endif
                end
                default: begin
                    state_q <= StArb;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
module tb_sync_fifo_wr_arb;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned DW      = 16;
    localparam int unsigned BL      = 8;
    localparam int unsigned TO      = 16;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic [3:0] grant;
    logic [1:0] grant_id;
    logic       busy;

    int tests = 0;
    int fails = 0;

    sync_fifo_wr_arb_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) bus ();

    sync_fifo_wr_arb #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL),
        .TIMEOUT    (TO)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .bus      (bus),
        .grant    (grant),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic set_data(input int i, input logic [DW-1:0] d);
        bus.req_data[i*DW +: DW] = d;
    endtask

    task automatic apply_reset();
        @(negedge sys_clk);
        sys_rst       = 1'b0;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b1;
    endtask

    // ---------------------------------------------------------------- reset
    task automatic test_reset();
        @(negedge sys_clk);
        sys_rst       = 1'b0;
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b0000;
        bus.fifo_full = 1'b0;
        for (int i = 0; i < 4; i++) set_data(i, 16'($urandom));
        for (int r = 0; r < 2; r++) begin
            @(negedge sys_clk);
            #1;
            tests++;
            if (grant !== 4'b0) begin
                fails++; $display("FAIL reset_grant: got %b want 0000", grant);
            end
            tests++;
            if (bus.req_ready !== 4'b0 || bus.fifo_wr_en !== 1'b0) begin
                fails++;
                $display("FAIL reset_handshake: ready=%b wr_en=%b want 0000/0",
                         bus.req_ready, bus.fifo_wr_en);
            end
            tests++;
            if (busy !== 1'b0 || grant_id !== 2'd0 || bus.fifo_din !== 16'h0) begin
                fails++;
                $display("FAIL reset_status: busy=%b grant_id=%0d din=%h want 0/0/0000",
                         busy, grant_id, bus.fifo_din);
            end
        end
    endtask

    // ---------------------------------------------- single requester, 3 beats
    task automatic test_single();
        logic [DW-1:0] d [3];
        int k   = 0;
        int nwr = 0;
        apply_reset();
        for (int i = 0; i < 3; i++) d[i] = 16'($urandom);
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge sys_clk);
            bus.req_valid = (k < 3) ? 4'b0100 : 4'b0000;
            bus.req_last  = (k == 2) ? 4'b0100 : 4'b0000;
            set_data(2, d[(k < 3) ? k : 2]);
            #1;
            if (cyc == 0) begin
                tests++;
                if (grant !== 4'b0 || bus.fifo_wr_en !== 1'b0) begin
                    fails++;
                    $display("FAIL single_bubble: grant=%b wr_en=%b want 0000/0",
                             grant, bus.fifo_wr_en);
                end
            end
            if (bus.fifo_wr_en === 1'b1) begin
                tests++;
                if (k >= 3) begin
                    fails++; $display("FAIL single_extra_beat: got beat %0d want none", k);
                end else if (grant !== 4'b0100 || bus.fifo_din !== d[k] ||
                             bus.req_ready !== 4'b0100) begin
                    fails++;
                    $display("FAIL single_beat%0d: grant=%b din=%h ready=%b want 0100/%h/0100",
                             k, grant, bus.fifo_din, bus.req_ready, d[k]);
                end
                nwr++;
                if (k < 3) k++;
            end
        end
        tests++;
        if (nwr !== 3) begin
            fails++; $display("FAIL single_count: got %0d beats want 3", nwr);
        end
        tests++;
        if (grant !== 4'b0 || busy !== 1'b0 || grant_id !== 2'd2) begin
            fails++;
            $display("FAIL single_release: grant=%b busy=%b id=%0d want 0000/0/2",
                     grant, busy, grant_id);
        end
        @(negedge sys_clk);
        bus.req_valid = 4'b1111;
        bus.req_last  = 4'b0000;
        #1;
        @(negedge sys_clk);
        #1;
        tests++;
        if (grant !== 4'b1000 || grant_id !== 2'd3) begin
            fails++;
            $display("FAIL single_next_rr: grant=%b id=%0d want 1000/3", grant, grant_id);
        end
    endtask

    // ------------------------------------------- all requesters, full bursts
    task automatic test_rounds();
        logic [DW-1:0] cur [4];
        logic [3:0]    exp;
        int            own;
        int            nwr = 0;
        apply_reset();
        for (int i = 0; i < 4; i++) cur[i] = 16'($urandom);
        for (int c = 0; c < 45; c++) begin
            @(negedge sys_clk);
            bus.req_valid = 4'b1111;
            bus.req_last  = 4'b0000;
            for (int i = 0; i < 4; i++) set_data(i, cur[i]);
            #1;
            // Period of 9: one arbitration cycle plus BL beats, owners 0,1,2,3,0.
            own = (c / 9) % 4;
            exp = (c % 9 == 0) ? 4'b0000 : (4'b0001 << own);
            tests++;
            if (grant !== exp || bus.fifo_wr_en !== (exp != 4'b0) ||
                (exp != 4'b0 && bus.fifo_din !== cur[own])) begin
                fails++;
                $display("FAIL rounds_c%0d: grant=%b wr_en=%b din=%h want %b/%b/%h",
                         c, grant, bus.fifo_wr_en, bus.fifo_din, exp, (exp != 4'b0), cur[own]);
            end
            if (bus.fifo_wr_en === 1'b1) nwr++;
            if (exp != 4'b0) cur[own] = 16'($urandom);
        end
        tests++;
        if (nwr !== 40) begin
            fails++; $display("FAIL rounds_count: got %0d beats want 40", nwr);
        end
    endtask

    // ------------------------------------------------ fifo full mid-burst
    task automatic test_full();
        logic [DW-1:0] beats [8];
        int b       = 0;
        int stall   = 0;
        bit pending = 0;
        bit done    = 0;
        apply_reset();
        for (int i = 0; i < 8; i++) beats[i] = 16'($urandom);
        for (int c = 0; c < 30; c++) begin
            @(negedge sys_clk);
            bus.fifo_full = (b == 3 && stall < 5);
            bus.req_valid = (b < 8) ? 4'b0001 : 4'b0000;
            bus.req_last  = 4'b0000;
            set_data(0, beats[(b < 8) ? b : 7]);
            #1;
            if (pending) begin
                tests++;
                if (grant !== 4'b0 || busy !== 1'b0 || bus.fifo_wr_en !== 1'b0) begin
                    fails++;
                    $display("FAIL full_release: grant=%b busy=%b wr_en=%b want 0000/0/0",
                             grant, busy, bus.fifo_wr_en);
                end
                pending = 0;
                done    = 1;
            end
            if (bus.fifo_full) begin
                tests++;
                if (bus.fifo_wr_en !== 1'b0 || bus.req_ready !== 4'b0 || grant !== 4'b0001) begin
                    fails++;
                    $display("FAIL full_stall%0d: wr_en=%b ready=%b grant=%b want 0/0000/0001",
                             stall, bus.fifo_wr_en, bus.req_ready, grant);
                end
                stall++;
            end else if (b < 8 && bus.fifo_wr_en === 1'b1) begin
                tests++;
                if (bus.fifo_din !== beats[b] || grant !== 4'b0001) begin
                    fails++;
                    $display("FAIL full_beat%0d: din=%h grant=%b want %h/0001",
                             b, bus.fifo_din, grant, beats[b]);
                end
                b++;
                if (b == 8) pending = 1;
            end
        end
        bus.fifo_full = 1'b0;
        tests++;
        if (b !== 8 || stall !== 5 || !done) begin
            fails++;
            $display("FAIL full_total: beats=%0d stalls=%0d released=%0d want 8/5/1",
                     b, stall, done);
        end
    endtask

    // ------------------------------------------ owner drops valid mid-burst
    task automatic test_drop();
        logic [3:0] exp;
        int  b1 = 0;
        int  j  = 0;
        bit  idle;
        apply_reset();
        for (int c = 0; c < 40 && j < 20; c++) begin
            @(negedge sys_clk);
            idle          = (b1 == 3);
            bus.req_valid = {1'b0, 1'b1, ~idle, 1'b0};
            bus.req_last  = 4'b0000;
            set_data(1, 16'($urandom));
            set_data(2, 16'($urandom));
            #1;
            if (idle) begin
`ifdef ARB_TIMEOUT_EN
                exp = (j < 16) ? 4'b0010 : ((j == 16) ? 4'b0000 : 4'b0100);
`else
                exp = 4'b0010;
`endif
                tests++;
                if (grant !== exp) begin
                    fails++; $display("FAIL drop_idle%0d: grant=%b want %b", j, grant, exp);
                end
                j++;
            end else if (bus.fifo_wr_en === 1'b1 && grant === 4'b0010) begin
                b1++;
            end
        end
        tests++;
        if (j !== 20) begin
            fails++; $display("FAIL drop_reach: idle cycles %0d want 20", j);
        end
        @(negedge sys_clk);
        bus.req_valid = 4'b0110;
        #1;
`ifdef ARB_TIMEOUT_EN
        exp = 4'b0100;
`else
        exp = 4'b0010;
`endif
        tests++;
        if (grant !== exp || bus.fifo_wr_en !== 1'b1) begin
            fails++;
            $display("FAIL drop_resume: grant=%b wr_en=%b want %b/1", grant, bus.fifo_wr_en, exp);
        end
    endtask

    // ------------------------------------------------ reset mid-burst
    task automatic test_reset_mid();
        int b   = 0;
        bit hit = 0;
        apply_reset();
        for (int c = 0; c < 12 && !hit; c++) begin
            @(negedge sys_clk);
            bus.req_valid = 4'b0100;
            bus.req_last  = 4'b0000;
            set_data(2, 16'($urandom));
            #1;
            if (bus.fifo_wr_en === 1'b1) begin
                b++;
                if (b == 4) begin
                    hit     = 1;
                    sys_rst = 1'b0;
                    #1;
                    tests++;
                    if (grant !== 4'b0 || bus.fifo_wr_en !== 1'b0 || bus.req_ready !== 4'b0 ||
                        busy !== 1'b0) begin
                        fails++;
                        $display("FAIL rstmid_clear: grant=%b wr_en=%b ready=%b busy=%b want 0",
                                 grant, bus.fifo_wr_en, bus.req_ready, busy);
                    end
                end
            end
        end
        tests++;
        if (!hit) begin
            fails++; $display("FAIL rstmid_reach: beats %0d want 4", b);
        end
        @(negedge sys_clk);
        sys_rst       = 1'b1;
        bus.req_valid = 4'b1111;
        #1;
        @(negedge sys_clk);
        #1;
        tests++;
        if (grant !== 4'b0001 || grant_id !== 2'd0) begin
            fails++;
            $display("FAIL rstmid_first: grant=%b id=%0d want 0001/0", grant, grant_id);
        end
    endtask

    // ------------------------------------------ randomized vs reference model
    task automatic test_random();
        logic [DW-1:0] cur_d [4];
        logic          cur_l [4];
        logic [3:0]    v;
        logic [3:0]    exp_grant;
        logic [3:0]    exp_ready;
        logic [DW-1:0] exp_din;
        logic          exp_acc;
        logic          full;
        logic          was_last;
        int m_owner = -1;
        int m_last  = 3;
        int m_beats = 0;
        int m_idle  = 0;
        int m_wr    = 0;
        int d_wr    = 0;
        int idx;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            cur_d[i] = 16'($urandom);
            cur_l[i] = ($urandom_range(0, 5) == 0);
        end
        for (int c = 0; c < 3000; c++) begin
            @(negedge sys_clk);
            full = ($urandom_range(0, 99) < 20);
            for (int i = 0; i < 4; i++) begin
                v[i] = ($urandom_range(0, 99) < 65);
                bus.req_last[i] = cur_l[i];
                set_data(i, cur_d[i]);
            end
            bus.req_valid = v;
            bus.fifo_full = full;
            #1;
            exp_grant = (m_owner < 0) ? 4'b0 : (4'b0001 << m_owner);
            exp_ready = full ? 4'b0 : exp_grant;
            exp_acc   = (m_owner >= 0) && v[m_owner] && !full;
            exp_din   = (m_owner >= 0) ? cur_d[m_owner] : '0;
            tests++;
            if (grant !== exp_grant || busy !== (m_owner >= 0) || bus.req_ready !== exp_ready ||
                bus.fifo_wr_en !== exp_acc || bus.fifo_din !== exp_din ||
                (m_owner >= 0 && grant_id !== 2'(m_owner))) begin
                fails++;
                if (fails < 20)
                    $display("FAIL random_c%0d: grant=%b busy=%b ready=%b wr_en=%b din=%h id=%0d want %b/%b/%b/%b/%h/%0d",
                             c, grant, busy, bus.req_ready, bus.fifo_wr_en, bus.fifo_din,
                             grant_id, exp_grant, (m_owner >= 0), exp_ready, exp_acc, exp_din,
                             m_owner);
            end
            if (bus.fifo_wr_en === 1'b1) d_wr++;
            // Reference model: one step of the arbitration rules.
            if (m_owner < 0) begin
                if (v != 4'b0) begin
                    for (int k = 1; k <= 4; k++) begin
                        idx = (m_last + k) % 4;
                        if (m_owner < 0 && v[idx]) m_owner = idx;
                    end
                    m_last  = m_owner;
                    m_beats = 0;
                    m_idle  = 0;
                end
            end else if (exp_acc) begin
                m_wr++;
                m_beats++;
                m_idle   = 0;
                was_last = cur_l[m_owner];
                cur_d[m_owner] = 16'($urandom);
                cur_l[m_owner] = ($urandom_range(0, 5) == 0);
                if (was_last || m_beats == BL) m_owner = -1;
            end else begin
`ifdef ARB_TIMEOUT_EN
                if (full) begin
                    m_idle = 0;
                end else begin
                    m_idle++;
                    if (m_idle == TO) m_owner = -1;
                end
`endif
            end
        end
        bus.fifo_full = 1'b0;
        tests++;
        if (d_wr !== m_wr || m_wr == 0) begin
            fails++; $display("FAIL random_count: dut beats %0d want %0d", d_wr, m_wr);
        end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        test_reset();
        test_single();
        test_rounds();
        test_full();
        test_drop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
